// File: rtl/hdr_msg_pkg.sv
// rtl/hdr_msg_pkg.sv - shared header format constants and receiver state encoding
package hdr_msg_pkg;

    localparam logic [15:0] SYNC_WORD    = 16'h1234;
    localparam int          HEADER_BYTES = 8;

    // Byte offsets of each 16-bit field on the wire, LSB byte first
    localparam int SYNC_OFFSET       = 0;
    localparam int BYTE_COUNT_OFFSET = 2;
    localparam int MSG_ID_OFFSET     = 4;
    localparam int SEQ_NUMBER_OFFSET = 6;

    localparam int STAGE_BITS = 48;

    typedef enum logic [1:0] {
        HUNT0  = 2'd0,
        HUNT1  = 2'd1,
        FIELDS = 2'd2
    } rx_state_e;

    // Bit position of a field inside the staging register once all field bytes are in
    function automatic int field_lsb(input int byte_offset);
        return (byte_offset - BYTE_COUNT_OFFSET) * 8;
    endfunction

endpackage

// File: rtl/header_msg_receiver_if.sv
// rtl/header_msg_receiver_if.sv - byte input and parsed message output bundle
interface header_msg_receiver_if;
    logic        ByteReady;
    logic [7:0]  InputByte;
    logic        MsgComplete;
    logic [15:0] MsgID;
    logic [15:0] SeqNumber;
    logic        BadLength;
    logic        Timeout;

    modport master (
        output ByteReady, InputByte,
        input  MsgComplete, MsgID, SeqNumber, BadLength, Timeout
    );

    modport slave (
        input  ByteReady, InputByte,
        output MsgComplete, MsgID, SeqNumber, BadLength, Timeout
    );
endinterface

// File: rtl/inter_byte_timer.sv
// rtl/inter_byte_timer.sv - inter-byte gap counter, flags expiry after TimeoutCycles idle clocks
module inter_byte_timer #(
    parameter int TimeoutCycles = 100000
) (
    input  logic Clock,
    input  logic Clear,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TimeoutCycles + 1);

    logic [W-1:0] count_q, count_d;

    // A byte on the expiry cycle clears the counter and suppresses expiry
    assign expired = en && !clr && (count_q == W'(TimeoutCycles));

    always_comb begin
        count_d = count_q;
        if (clr || !en || expired) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/header_msg_receiver.sv
// rtl/header_msg_receiver.sv - sync-hunting header parser; HDR_RX_TIMEOUT_EN adds an inter-byte timeout
module header_msg_receiver
    import hdr_msg_pkg::*;
#(
    parameter logic [15:0] SyncWord      = SYNC_WORD,
    parameter int          HeaderBytes   = HEADER_BYTES,
    parameter int          TimeoutCycles = 100000
) (
    input  logic                 Clock,
    input  logic                 Clear,
    header_msg_receiver_if.slave bus
);
    localparam int         BcLsb   = field_lsb(BYTE_COUNT_OFFSET);
    localparam int         IdLsb   = field_lsb(MSG_ID_OFFSET);
    localparam int         SeqLsb  = field_lsb(SEQ_NUMBER_OFFSET);
    localparam logic [2:0] LastCnt = 3'(HeaderBytes - 3);

    rx_state_e              state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [STAGE_BITS-1:0]  stage_q, stage_d;
    logic [15:0]            msg_id_q, msg_id_d;
    logic [15:0]            seq_q, seq_d;
    logic                   complete_q, complete_d;
    logic                   bad_q, bad_d;
    logic                   timeout_q, timeout_d;

`ifdef HDR_RX_TIMEOUT_EN
    logic timer_expired;

    inter_byte_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .Clock  (Clock),
        .Clear  (Clear),
        .clr    (bus.ByteReady),
        .en     (state_q != HUNT0),
        .expired(timer_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        msg_id_d   = msg_id_q;
        seq_d      = seq_q;
        complete_d = 1'b0;
        bad_d      = 1'b0;
        timeout_d  = 1'b0;

        // Staging only shifts in FIELDS, so it still holds the header one edge later
        if (complete_q) begin
            msg_id_d = stage_q[IdLsb +: 16];
            seq_d    = stage_q[SeqLsb +: 16];
        end

        if (bus.ByteReady) begin
            case (state_q)
                HUNT0: begin
                    if (bus.InputByte == SyncWord[7:0]) state_d = HUNT1;
                end
                HUNT1: begin
                    if (bus.InputByte == SyncWord[15:8]) begin
                        state_d = FIELDS;
                        cnt_d   = '0;
                    end else if (bus.InputByte == SyncWord[7:0]) begin
                        state_d = HUNT1;
                    end else begin
                        state_d = HUNT0;
                    end
                end
                FIELDS: begin
                    stage_d = {bus.InputByte, stage_q[STAGE_BITS-1:8]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LastCnt) begin
                        state_d = HUNT0;
                        cnt_d   = '0;
                        if (stage_d[BcLsb +: 16] == 16'(HeaderBytes)) complete_d = 1'b1;
                        else                                         bad_d      = 1'b1;
                    end
                end
                default: state_d = HUNT0;
            endcase
        end
`ifdef HDR_RX_TIMEOUT_EN
        else if (timer_expired) begin
            state_d   = HUNT0;
            cnt_d     = '0;
            timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q    <= HUNT0;
            cnt_q      <= '0;
            stage_q    <= '0;
            msg_id_q   <= '0;
            seq_q      <= '0;
            complete_q <= 1'b0;
            bad_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            msg_id_q   <= msg_id_d;
            seq_q      <= seq_d;
            complete_q <= complete_d;
            bad_q      <= bad_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.MsgComplete = complete_q;
    assign bus.BadLength   = bad_q;
    assign bus.MsgID       = msg_id_q;
    assign bus.SeqNumber   = seq_q;
`ifdef HDR_RX_TIMEOUT_EN
    assign bus.Timeout     = timeout_q;
`else
    assign bus.Timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_header_msg_receiver.sv
// tb/tb_header_msg_receiver.sv - table-driven scoreboard bench for header_msg_receiver
module tb_header_msg_receiver;

`ifdef HDR_RX_TIMEOUT_EN
    localparam int TB_TIMEOUT = 50;
`else
    localparam int TB_TIMEOUT = 100000;
`endif

    localparam int K_NONE = 0, K_COMPLETE = 1, K_BAD = 2, K_TIMEOUT = 3;

    typedef struct {
        logic [95:0] bytes;
        int          n;
        int          kind;
        logic [15:0] id;
        logic [15:0] seq;
    } vec_t;

    typedef struct {
        int          kind;
        logic [15:0] id;
        logic [15:0] seq;
    } exp_t;

    logic Clock;
    logic Clear;
    header_msg_receiver_if bus ();

    header_msg_receiver #(
        .SyncWord     (16'h1234),
        .HeaderBytes  (8),
        .TimeoutCycles(TB_TIMEOUT)
    ) dut (
        .Clock(Clock),
        .Clear(Clear),
        .bus  (bus.slave)
    );

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        exp_q[$];
    int          ctimes[$];
    logic [15:0] model_id  = 16'h0;
    logic [15:0] model_seq = 16'h0;
    vec_t        vecs[9];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        bus.ByteReady = 1'b1;
        bus.InputByte = b;
        @(negedge Clock);
    endtask

    task automatic idle(input int k);
        bus.ByteReady = 1'b0;
        repeat (k) @(negedge Clock);
    endtask

    task automatic send(input logic [95:0] bytes, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            drive(bytes[(n - 1 - i) * 8 +: 8]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        idle(0);
    endtask

    task automatic expect_msg(input int kind, input logic [15:0] id, input logic [15:0] seq);
        exp_t e;
        e.kind = kind;
        e.id   = id;
        e.seq  = seq;
        exp_q.push_back(e);
        if (kind == K_COMPLETE) begin
            model_id  = id;
            model_seq = seq;
        end
    endtask

    // Scoreboard monitor: every output pulse must match the oldest expectation
    initial begin
        exp_t e;
        int   got;
        forever begin
            @(negedge Clock);
            if (bus.MsgComplete || bus.BadLength || bus.Timeout) begin
                got = bus.MsgComplete ? K_COMPLETE : (bus.BadLength ? K_BAD : K_TIMEOUT);
                if (bus.MsgComplete) ctimes.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("pulse_without_expect", got, K_NONE);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", got, e.kind);
                    if (e.kind == K_COMPLETE) begin
                        @(negedge Clock);
                        chk("msg_id", bus.MsgID, e.id);
                        chk("seq_number", bus.SeqNumber, e.seq);
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{96'h3412_0800_6500_0700,      8,  K_COMPLETE, 16'h0065, 16'h0007};
        vecs[1] = '{96'h3412_0900_6500_0700,      8,  K_BAD,      16'h0,    16'h0};
        vecs[2] = '{96'h5534_3412_0800_6600_0100, 10, K_COMPLETE, 16'h0066, 16'h0001};
        vecs[3] = '{96'h3412_0800_ABCD_3412,      8,  K_COMPLETE, 16'hCDAB, 16'h1234};
        vecs[4] = '{96'h12_3412_0800_0100_0200,   9,  K_COMPLETE, 16'h0001, 16'h0002};
        vecs[5] = '{96'h3455_3412_0800_1100_2200, 10, K_COMPLETE, 16'h0011, 16'h0022};
        vecs[6] = '{96'h3412_0008_0100_0200,      8,  K_BAD,      16'h0,    16'h0};
        vecs[7] = '{96'h3434_3412_0800_FFFF_FFFF, 10, K_COMPLETE, 16'hFFFF, 16'hFFFF};
        vecs[8] = '{96'h3413_0800_6500_0700,      8,  K_NONE,     16'h0,    16'h0};

        bus.ByteReady = 1'b0;
        bus.InputByte = 8'h00;
        Clear = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_complete", bus.MsgComplete, 0);
        chk("rst_badlength", bus.BadLength, 0);
        chk("rst_timeout", bus.Timeout, 0);
        chk("rst_msg_id", bus.MsgID, 0);
        chk("rst_seq", bus.SeqNumber, 0);
        Clear = 1'b1;
        idle(2);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].kind != K_NONE) expect_msg(vecs[v].kind, vecs[v].id, vecs[v].seq);
            send(vecs[v].bytes, vecs[v].n, (v % 2 == 1) ? 2 : 0);
            idle(4);
            chk($sformatf("vec%0d_drained", v), exp_q.size(), 0);
            chk($sformatf("vec%0d_id_hold", v), bus.MsgID, model_id);
            chk($sformatf("vec%0d_seq_hold", v), bus.SeqNumber, model_seq);
        end

        // Reset in the middle of a header discards it silently
        send(96'h34_1208_0065, 5, 0);
        Clear = 1'b0;
        idle(2);
        chk("midrst_msg_id", bus.MsgID, 0);
        chk("midrst_seq", bus.SeqNumber, 0);
        Clear = 1'b1;
        model_id  = 16'h0;
        model_seq = 16'h0;
        idle(1);
        expect_msg(K_COMPLETE, 16'h0077, 16'h0009);
        send(96'h3412_0800_7700_0900, 8, 0);
        idle(4);
        chk("midrst_drained", exp_q.size(), 0);

        // Two headers at full rate, second sync byte right after the first final byte
        ctimes.delete();
        expect_msg(K_COMPLETE, 16'h0101, 16'h0202);
        expect_msg(K_COMPLETE, 16'h0303, 16'h0404);
        send(96'h3412_0800_0101_0202, 8, 0);
        send(96'h3412_0800_0303_0404, 8, 0);
        idle(4);
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_count", ctimes.size(), 2);
        if (ctimes.size() >= 2) chk("b2b_spacing", ctimes[1] - ctimes[0], 8);

        // Partial header followed by a long idle gap
`ifdef HDR_RX_TIMEOUT_EN
        expect_msg(K_TIMEOUT, 16'h0, 16'h0);
        send(96'h341208, 3, 0);
        idle(60);
        chk("timeout_drained", exp_q.size(), 0);
        expect_msg(K_COMPLETE, 16'h0065, 16'h0007);
        send(96'h3412_0800_6500_0700, 8, 0);
`else
        send(96'h341208, 3, 0);
        idle(60);
        chk("no_timeout_pending", exp_q.size(), 0);
        expect_msg(K_COMPLETE, 16'h0065, 16'h0007);
        send(96'h00_6500_0700, 5, 0);
`endif
        idle(4);
        chk("final_drained", exp_q.size(), 0);
        chk("final_msg_id", bus.MsgID, model_id);
        chk("final_seq", bus.SeqNumber, model_seq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/header_msg_receiver.md
HEADER_MSG_RECEIVER -- requirements
Module: header_msg_receiver

Interface
REQ-001 SHALL have parameter SyncWord, default 16'h1234, the expected header sync word.
REQ-002 SHALL have parameter HeaderBytes, default 8, the header length in bytes.
REQ-003 SHALL have parameter TimeoutCycles, default 100000, the inter-byte gap limit in clocks; it is used only with HDR_RX_TIMEOUT_EN.
REQ-004 SHALL have port Clock, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Clear, input, 1, the reset; asynchronous, active-low.
REQ-006 SHALL have port ByteReady, input, 1, a one-cycle pulse from the S2P deserializer meaning InputByte is valid.
REQ-007 SHALL have port InputByte, input, 8, the received byte.
REQ-008 SHALL have port MsgComplete, output, 1, a one-cycle pulse meaning a valid header-only message was received.
REQ-009 SHALL have port MsgID, output, 16, the ID of the last valid message.
REQ-010 SHALL have port SeqNumber, output, 16, the sequence number of the last valid message.
REQ-011 SHALL have port BadLength, output, 1, a one-cycle pulse meaning the header parsed but its ByteCount did not equal HeaderBytes.
REQ-012 SHALL have port Timeout, output, 1, a one-cycle pulse on inter-byte timeout; it is tied 0 when the feature is excluded.

Function
REQ-013 SHALL parse the wire format: Sync, ByteCount, MsgID, SeqNumber, each 16 bits, each sent LSB byte first.
REQ-014 SHALL implement states HUNT0, HUNT1 and FIELDS, with a 3-bit field-byte counter; only cycles with ByteReady=1 advance the FSM.
REQ-015 In HUNT0: byte == SyncWord[7:0] -> HUNT1; any other byte -> stay in HUNT0.
REQ-016 In HUNT1: byte == SyncWord[15:8] -> FIELDS with counter=0; byte == SyncWord[7:0] -> stay in HUNT1 (resync); any other byte -> HUNT0.
REQ-017 In FIELDS: each byte SHALL be shifted into a 48-bit staging register and the counter incremented; the byte completing HeaderBytes-2 field bytes ends the header.
REQ-018 On the final header byte (edge N): state -> HUNT0, and the ByteCount check SHALL be made on the assembled value, including that final byte.
REQ-019 If ByteCount == HeaderBytes: MsgComplete=1 for exactly the cycle after edge N, and MsgID/SeqNumber SHALL update at edge N+1.
REQ-020 Otherwise: BadLength=1 for the cycle after edge N, and MsgID/SeqNumber SHALL be unchanged.
REQ-021 MsgID/SeqNumber SHALL hold their values until the next valid message.
REQ-022 A ByteReady arriving the cycle after the final header byte SHALL be processed in HUNT0; no byte is dropped.
REQ-023 Back-to-back ByteReady pulses, one per clock, SHALL be handled at full rate.
REQ-024 Errors SHALL NOT stall the FSM; it returns to hunting immediately.

Reset
REQ-025 On Clear=0, asynchronously: state=HUNT0, counter=0, staging=0, MsgID=0, SeqNumber=0, MsgComplete=0, BadLength=0, Timeout=0, timer=0.
REQ-026 Reset mid-header SHALL discard the partial header, and no pulse SHALL be emitted for it.

Configuration
REQ-027 With macro HDR_RX_TIMEOUT_EN defined: a counter SHALL clear on every ByteReady and count while state != HUNT0.
REQ-028 With HDR_RX_TIMEOUT_EN defined: when the counter reaches TimeoutCycles, state -> HUNT0, counter -> 0, and Timeout pulses for 1 cycle.
REQ-029 With HDR_RX_TIMEOUT_EN defined: a ByteReady on the same cycle the counter expires SHALL win, so no timeout fires and the byte is processed.
REQ-030 With HDR_RX_TIMEOUT_EN undefined: no counter logic SHALL be present, Timeout SHALL be constant 0, and a partial header SHALL wait indefinitely.

Structure
REQ-031 Package hdr_msg_pkg SHALL hold the default SYNC_WORD, HEADER_BYTES, the field byte offsets and the state encoding, shared with the sender side.
REQ-032 Sub-module inter_byte_timer SHALL hold the timeout counter and be instantiated only under HDR_RX_TIMEOUT_EN.

Verification
REQ-033 Send 34 12 08 00 65 00 07 00 -> MsgComplete pulses once; MsgID=0x0065, SeqNumber=0x0007.
REQ-034 Send 34 12 09 00 65 00 07 00 -> BadLength pulses once, no MsgComplete, and MsgID/SeqNumber are unchanged.
REQ-035 Send 55 34 34 12 08 00 66 00 01 00 -> resync succeeds; MsgComplete with MsgID=0x0066, SeqNumber=0x0001.
REQ-036 Assert Clear=0 after 5 bytes, release it, then send a full valid header -> exactly one MsgComplete, carrying the new values.
REQ-037 Send two valid headers with ByteReady every clock -> two MsgComplete pulses, 8 clocks apart.
REQ-038 With HDR_RX_TIMEOUT_EN and TimeoutCycles=50: send 34 12 08, then idle 60 clocks -> Timeout pulses; a following full header -> MsgComplete.
